// File: rtl/req_pending_latch_pkg.sv
// Shared definitions for the request-pending latch.
//   NSRC   : number of request sources
//   IDX_W  : width of an encoded source index
//   state_t: grant FSM states
package req_pending_latch_pkg;

  localparam int NSRC  = 4;
  localparam int IDX_W = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT  = 2'd1,
    SETTLE = 2'd2
  } state_t;

endpackage

// File: rtl/req_edge_detect.sv
// Rising-edge detector for the raw request lines.
//   clk  : clock
//   rst  : synchronous active-high reset, clears the edge history
//   req  : raw request lines
//   rise : 1 for each line that is high now and was low last cycle
// Because the history clears to 0, a line already high in the first
// cycle after reset shows up as a rise.
module req_edge_detect
  import req_pending_latch_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic [NSRC-1:0] req,
  output logic [NSRC-1:0] rise
);

  logic [NSRC-1:0] req_p0;

  // stage p0: previous-cycle request history
  always_ff @(posedge clk) begin
    if (rst) begin
      req_p0 <= '0;
    end else begin
      req_p0 <= req;
    end
  end

  assign rise = req & ~req_p0;

endmodule

// File: rtl/req_pending_latch.sv
// Captures request rising edges into a pending vector, presents the
// unmasked part to an external priority encoder, and runs a three-state
// grant handshake (IDLE -> GRANT -> SETTLE) with a timeout.
//   clk         : clock
//   rst         : synchronous active-high reset, overrides everything
//   req         : raw request lines, bit 3 highest priority
//   mask        : 1 hides a pending bit from the encoder (bit stays captured)
//   pending     : registered pending vector & ~mask, to the encoder
//   enc_idx     : encoder result index
//   enc_valid   : encoder result valid
//   grant_id    : index of the granted source
//   grant_valid : grant offered (high throughout GRANT)
//   grant_ack   : consumer accepts the grant (ignored outside GRANT)
//   timeout_err : one-cycle pulse when a grant is abandoned
//   grant_count : saturating count of acknowledged grants
module req_pending_latch
  import req_pending_latch_pkg::*;
#(
  parameter int TIMEOUT = 15,
  parameter int CNT_W   = 8
)
(
  input  logic             clk,
  input  logic             rst,
  input  logic [NSRC-1:0]  req,
  input  logic [NSRC-1:0]  mask,
  output logic [NSRC-1:0]  pending,
  input  logic [IDX_W-1:0] enc_idx,
  input  logic             enc_valid,
  output logic [IDX_W-1:0] grant_id,
  output logic             grant_valid,
  input  logic             grant_ack,
  output logic             timeout_err,
  output logic [CNT_W-1:0] grant_count
);

  localparam int              TCNT_W = 8;
  localparam logic [TCNT_W-1:0] TLAST = TCNT_W'(TIMEOUT - 1);

  state_t              state;
  state_t              state_nxt;
  logic [NSRC-1:0]     rise;
  logic [NSRC-1:0]     pending_p1;
  logic [NSRC-1:0]     clr;
  logic [TCNT_W-1:0]   tcnt;
  logic                do_latch;
  logic                do_ack;
  logic                do_timeout;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  req_edge_detect u_edge (
    .clk  (clk),
    .rst  (rst),
    .req  (req),
    .rise (rise)
  );

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM next state and per-cycle actions; ack wins over a timeout
  // landing in the same cycle.
  always_comb begin
    state_nxt  = state;
    do_latch   = 1'b0;
    do_ack     = 1'b0;
    do_timeout = 1'b0;
    case (state)
      IDLE: begin
        if (enc_valid) begin
          do_latch  = 1'b1;
          state_nxt = GRANT;
        end
      end
      GRANT: begin
        if (grant_ack) begin
          do_ack    = 1'b1;
          state_nxt = SETTLE;
        end else if (tcnt == TLAST) begin
          do_timeout = 1'b1;
          state_nxt  = SETTLE;
        end
      end
      SETTLE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Clear targets the latched grant_id, not the masked view, so a mask
  // raised during GRANT still retires the captured bit on ack.
  always_comb begin
    clr = '0;
    if (do_ack) begin
      clr[grant_id] = 1'b1;
    end
  end

  // stage p1: pending vector, grant bookkeeping and timeout counter.
  // A rise in the same cycle as a clear re-sets the bit (set wins).
  always_ff @(posedge clk) begin
    if (rst) begin
      pending_p1  <= '0;
      grant_id    <= '0;
      timeout_err <= 1'b0;
      grant_count <= '0;
      tcnt        <= '0;
    end else begin
      pending_p1  <= (pending_p1 & ~clr) | rise;
      timeout_err <= do_timeout;
      if (do_latch) begin
        grant_id <= enc_idx;
      end
      if (do_ack) begin
        grant_count <= sat_inc(grant_count);
      end
      // Counts only while staying in GRANT; zero on entry and elsewhere.
      if ((state == GRANT) && (state_nxt == GRANT)) begin
        tcnt <= tcnt + 1'b1;
      end else begin
        tcnt <= '0;
      end
    end
  end

  assign grant_valid = (state == GRANT);
  assign pending     = pending_p1 & ~mask;

endmodule

// File: tb/tb_req_pending_latch.sv
// Bench for req_pending_latch: a behavioural priority encoder closes the
// loop, expected grant ids are queued as requests are driven and popped
// when a new grant appears, and a small model tracks the ack count.
module tb_req_pending_latch;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic [3:0] mask;
  logic [3:0] pending;
  logic [1:0] enc_idx;
  logic       enc_valid;
  logic [1:0] grant_id;
  logic       grant_valid;
  logic       grant_ack;
  logic       timeout_err;
  logic [7:0] grant_count;

  logic       auto_ack;
  logic       ack_force;

  int         n_cmp = 0;
  int         n_err = 0;
  int         exp_q[$];
  logic       gv_prev = 1'b0;
  int         cnt_model = 0;

  always #5 clk = ~clk;

  req_pending_latch #(.TIMEOUT(15), .CNT_W(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .mask        (mask),
    .pending     (pending),
    .enc_idx     (enc_idx),
    .enc_valid   (enc_valid),
    .grant_id    (grant_id),
    .grant_valid (grant_valid),
    .grant_ack   (grant_ack),
    .timeout_err (timeout_err),
    .grant_count (grant_count)
  );

  // Priority encoder model: highest set bit wins.
  always_comb begin
    enc_valid = |pending;
    enc_idx   = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (pending[i]) enc_idx = 2'(i);
    end
  end

  assign grant_ack = ack_force | (auto_ack & grant_valid);

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard pop on each new grant, and the acknowledged-grant model.
  always @(negedge clk) begin
    if (grant_valid && !gv_prev) begin
      if (exp_q.size() == 0) begin
        check_eq("sb_underflow", exp_q.size(), 1);
      end else begin
        check_eq("sb_grant_id", grant_id, exp_q.pop_front());
      end
    end
    gv_prev <= grant_valid;
    if (rst)
      cnt_model <= 0;
    else if (grant_valid && grant_ack && cnt_model < 255)
      cnt_model <= cnt_model + 1;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; req = 4'b0; mask = 4'b0; auto_ack = 1'b1; ack_force = 1'b0;
    tick(); tick();
    check_eq("rst_pending", pending, 0);
    check_eq("rst_gvalid", grant_valid, 0);
    check_eq("rst_gid", grant_id, 0);
    check_eq("rst_terr", timeout_err, 0);
    check_eq("rst_cnt", grant_count, 0);
    rst = 1'b0;
    tick();

    // Single request
    exp_q.push_back(2);
    req = 4'b0100;
    tick();
    check_eq("single_pending", pending, 4'b0100);
    check_eq("single_gv_early", grant_valid, 0);
    tick();
    check_eq("single_gv", grant_valid, 1);
    check_eq("single_gid", grant_id, 2);
    tick();
    check_eq("single_clear", pending, 0);
    check_eq("single_cnt", grant_count, 1);
    check_eq("single_settle_gv", grant_valid, 0);
    req = 4'b0; tick();

    // Priority order 3 then 1
    exp_q.push_back(3); exp_q.push_back(1);
    req = 4'b1010;
    tick();
    check_eq("prio_pending", pending, 4'b1010);
    tick();
    check_eq("prio_gid0", grant_id, 3);
    tick();
    check_eq("prio_pending_mid", pending, 4'b0010);
    check_eq("prio_settle_gv", grant_valid, 0);
    tick();
    check_eq("prio_idle_gv", grant_valid, 0);
    tick();
    check_eq("prio_gv1", grant_valid, 1);
    check_eq("prio_gid1", grant_id, 1);
    tick();
    check_eq("prio_pending_end", pending, 0);
    check_eq("prio_cnt", grant_count, cnt_model);
    req = 4'b0; tick();

    // Timeout after 15 GRANT cycles, then re-grant
    auto_ack = 1'b0;
    exp_q.push_back(0); exp_q.push_back(0);
    req = 4'b0001;
    tick(); tick();
    check_eq("to_gv", grant_valid, 1);
    repeat (14) tick();
    check_eq("to_gv_last", grant_valid, 1);
    check_eq("to_terr_early", timeout_err, 0);
    tick();
    check_eq("to_terr", timeout_err, 1);
    check_eq("to_settle_gv", grant_valid, 0);
    check_eq("to_pending", pending, 4'b0001);
    tick();
    check_eq("to_terr_pulse", timeout_err, 0);
    tick();
    check_eq("to_regrant_gv", grant_valid, 1);
    check_eq("to_regrant_gid", grant_id, 0);
    auto_ack = 1'b1;
    tick();
    check_eq("to_clear", pending, 0);
    req = 4'b0; tick();

    // Set beats clear on id 2
    exp_q.push_back(2); exp_q.push_back(2);
    req = 4'b0100;
    tick();
    req = 4'b0000;
    tick();
    check_eq("sbc_gv", grant_valid, 1);
    req = 4'b0100;
    tick();
    check_eq("sbc_pending", pending, 4'b0100);
    tick(); tick();
    check_eq("sbc_regrant_gid", grant_id, 2);
    check_eq("sbc_regrant_gv", grant_valid, 1);
    tick();
    check_eq("sbc_clear", pending, 0);
    req = 4'b0; tick();

    // Mask hides id 3; mask during GRANT does not revoke
    mask = 4'b1000;
    exp_q.push_back(0);
    req = 4'b1001;
    tick();
    check_eq("mask_pending", pending, 4'b0001);
    tick();
    check_eq("mask_gid0", grant_id, 0);
    tick(); tick(); tick();
    check_eq("mask_hold_idle", grant_valid, 0);
    auto_ack = 1'b0;
    exp_q.push_back(3);
    mask = 4'b0000;
    tick();
    check_eq("unmask_gid", grant_id, 3);
    mask = 4'b1000;
    tick();
    check_eq("mask_norevoke_gv", grant_valid, 1);
    check_eq("mask_norevoke_gid", grant_id, 3);
    auto_ack = 1'b1;
    tick();
    mask = 4'b0000;
    tick();
    check_eq("mask_cleared", pending, 0);
    req = 4'b0; tick();

    // Saturation
    for (int i = 0; i < 300; i++) begin
      exp_q.push_back(0);
      req = 4'b0001; tick();
      req = 4'b0000; tick(); tick(); tick();
    end
    check_eq("sat_cnt", grant_count, 255);
    check_eq("sat_model", grant_count, cnt_model);

    // Reset in GRANT with ack; then held req counts as a rise
    exp_q.push_back(1);
    req = 4'b0010;
    tick(); tick();
    check_eq("rstg_gv", grant_valid, 1);
    ack_force = 1'b1; rst = 1'b1;
    tick();
    check_eq("rstg_pending", pending, 0);
    check_eq("rstg_gv0", grant_valid, 0);
    check_eq("rstg_gid", grant_id, 0);
    check_eq("rstg_terr", timeout_err, 0);
    check_eq("rstg_cnt", grant_count, 0);
    exp_q.push_back(1);
    rst = 1'b0; ack_force = 1'b0;
    tick();
    check_eq("post_rst_rise", pending, 4'b0010);
    tick();
    check_eq("post_rst_gid", grant_id, 1);
    tick();
    check_eq("post_rst_cnt", grant_count, 1);
    req = 4'b0; tick(); tick();

    check_eq("sb_drain", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
